// File: rtl/apb4_req_bridge_pkg.sv
// Shared types and constants for the request-to-APB4 bridge.
// Holds the bridge FSM encoding and the default access timeout.
package apb4_req_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 256;

  // Counter width able to hold the values 0 .. limit-1 (limit >= 2).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/apb4_timeout_cnt.sv
// Access-phase watchdog: counts stalled ACCESS cycles and flags the last
// allowed one, so the bridge can abandon a slave that never responds.
module apb4_timeout_cnt
  import apb4_req_bridge_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = cnt_width(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/apb4_req_bridge.sv
// Converts a valid/ready request/response pair into single APB4 transfers,
// with a bounded ACCESS phase that ends in an error response on timeout.
module apb4_req_bridge
  import apb4_req_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state;
  state_e                  state_next;
  logic                    accept;
  logic                    tmo_expired;
  logic                    hold_write;
  logic [ADDR_WIDTH-1:0]   hold_addr;
  logic [DATA_WIDTH-1:0]   hold_wdata;
  logic [STRB_WIDTH-1:0]   hold_strb;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  assign accept = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (accept) state_next = SETUP;
      end
      SETUP: begin
        psel_o     = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || tmo_expired) state_next = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read requests carry zero data and strobes onto the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_write <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_strb  <= '0;
    end else if (accept) begin
      hold_write <= req_write_i;
      hold_addr  <= req_addr_i;
      hold_wdata <= req_write_i ? req_wdata_i : '0;
      hold_strb  <= req_write_i ? req_wstrb_i : '0;
    end
  end

  // Slave response is only sampled on the completing ACCESS cycle; a ready
  // slave on the limit cycle wins over the timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      if (pready_i) begin
        rsp_rdata <= hold_write ? '0 : prdata_i;
        rsp_err   <= pslverr_i;
      end else if (tmo_expired) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

  apb4_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !pready_i),
    .expired (tmo_expired)
  );

  assign paddr_o     = hold_addr;
  assign pwrite_o    = hold_write;
  assign pwdata_o    = hold_wdata;
  assign pstrb_o     = hold_strb;
  assign pprot_o     = 3'b000;
  assign rsp_rdata_o = rsp_rdata;
  assign rsp_err_o   = rsp_err;

endmodule

// File: tb/tb_apb4_req_bridge.sv
// Directed and randomized bench for apb4_req_bridge with a transaction-level
// reference model of the bridge and a simple APB4 slave.
module tb_apb4_req_bridge;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;

  int checks = 0;
  int errors = 0;

  apb4_req_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .paddr_o     (paddr_o),
    .pprot_o     (pprot_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .pstrb_o     (pstrb_o),
    .pready_i    (pready_i),
    .prdata_i    (prdata_i),
    .pslverr_i   (pslverr_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave memory model: one fixed identification word, everything else
  // derived from the address.
  function automatic logic [31:0] slave_rd(input logic [31:0] addr);
    if (addr == 32'hFFFF_0000) return 32'h101F_1010;
    return ~addr ^ 32'h1357_9BDF;
  endfunction

  // One full request/response. waits = stalled ACCESS cycles before pready;
  // waits >= TMO means the slave never answers. hold = response cycles with
  // rsp_ready low before the consumer takes it.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input bit slverr,
                         input int hold);
    bit          tmo;
    int          acc;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    logic [31:0] exp_rdata;
    bit          exp_err;
    tmo       = (waits >= TMO);
    acc       = tmo ? TMO : waits + 1;
    exp_wdata = wr ? wdata : 32'h0;
    exp_strb  = wr ? strb : 4'h0;
    exp_err   = tmo ? 1'b1 : slverr;
    exp_rdata = (wr || tmo) ? 32'h0 : slave_rd(addr);

    @(negedge clk);
    check("idle_req_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_wstrb_i = strb;

    @(negedge clk);
    req_valid_i = 1'b0;
    req_write_i = 1'($urandom);
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_wstrb_i = 4'($urandom);
    check("setup_psel", psel_o, 1);
    check("setup_penable", penable_o, 0);
    check("setup_req_ready", req_ready_o, 0);
    check("setup_paddr", paddr_o, addr);
    check("setup_pwrite", pwrite_o, wr);
    check("setup_pwdata", pwdata_o, exp_wdata);
    check("setup_pstrb", pstrb_o, exp_strb);
    check("setup_pprot", pprot_o, 3'b000);

    for (int a = 0; a < acc; a++) begin
      @(negedge clk);
      check("access_psel", psel_o, 1);
      check("access_penable", penable_o, 1);
      check("access_paddr", paddr_o, addr);
      check("access_pwrite", pwrite_o, wr);
      check("access_pwdata", pwdata_o, exp_wdata);
      check("access_pstrb", pstrb_o, exp_strb);
      check("access_rsp_valid", rsp_valid_o, 0);
      if (!tmo && a == waits) begin
        pready_i  = 1'b1;
        pslverr_i = slverr;
        prdata_i  = slave_rd(addr);
      end else begin
        pready_i  = 1'b0;
        pslverr_i = 1'($urandom);
        prdata_i  = $urandom;
      end
    end

    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      if (h == 0) begin
        pready_i  = 1'b0;
        pslverr_i = 1'($urandom);
        prdata_i  = $urandom;
      end
      check("resp_valid", rsp_valid_o, 1);
      check("resp_rdata", rsp_rdata_o, exp_rdata);
      check("resp_err", rsp_err_o, exp_err);
      check("resp_psel", psel_o, 0);
      check("resp_penable", penable_o, 0);
      check("resp_req_ready", req_ready_o, 0);
      rsp_ready_i = (h == hold);
    end

    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("post_rsp_valid", rsp_valid_o, 0);
    check("post_req_ready", req_ready_o, 1);
    check("post_psel", psel_o, 0);
    check("post_paddr_hold", paddr_o, addr);
    check("post_pstrb_hold", pstrb_o, exp_strb);
  endtask

  initial begin
    int first_rise;
    int second_rise;
    bit prev_psel;
    bit drained;

    rst_i       = 1'b0;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    rsp_ready_i = 1'b0;
    pready_i    = 1'b0;
    prdata_i    = '0;
    pslverr_i   = 1'b0;

    // Reset state
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_psel", psel_o, 0);
    check("rst_penable", penable_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("rel_req_ready", req_ready_o, 1);
    check("rel_rsp_err", rsp_err_o, 0);
    check("rel_rsp_rdata", rsp_rdata_o, 32'h0);
    check("rel_paddr", paddr_o, 32'h0);
    check("rel_pwdata", pwdata_o, 32'h0);
    check("rel_pstrb", pstrb_o, 4'h0);
    check("rel_pwrite", pwrite_o, 0);

    // Archinfo read, zero wait states
    run_txn(1'b0, 32'hFFFF_0000, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0);
    // Write with three wait states
    run_txn(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'b0011, 3, 1'b0, 0);
    // Slave never ready: timeout
    run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1000, 1'b0, 1);
    run_txn(1'b1, 32'h0000_0044, 32'h1234_5678, 4'hF, TMO, 1'b0, 0);
    // Ready on the limit cycle completes normally
    run_txn(1'b0, 32'h0000_0080, 32'h0, 4'h0, TMO - 1, 1'b0, 0);
    run_txn(1'b0, 32'h0000_0084, 32'h0, 4'h0, TMO - 1, 1'b1, 0);
    // Slave error on read, response back-pressured 5 cycles
    run_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 1'b1, 5);

    // Reset asserted during ACCESS
    @(negedge clk);
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h0000_0200;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    check("mid_rst_pre_penable", penable_o, 1);
    pready_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_psel", psel_o, 0);
    check("mid_rst_penable", penable_o, 0);
    check("mid_rst_rsp_valid", rsp_valid_o, 0);
    check("mid_rst_req_ready", req_ready_o, 1);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_no_rsp", rsp_valid_o, 0);
    run_txn(1'b0, 32'hFFFF_0000, 32'h0, 4'h0, 1, 1'b0, 0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
              int'($urandom_range(0, 10)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Back-to-back requests with req_valid held high
    @(negedge clk);
    pready_i    = 1'b1;
    pslverr_i   = 1'b0;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h0000_0300;
    first_rise  = -1;
    second_rise = -1;
    prev_psel   = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (psel_o && !prev_psel) begin
        if (first_rise < 0) first_rise = c;
        else if (second_rise < 0) second_rise = c;
      end
      prev_psel = psel_o;
    end
    req_valid_i = 1'b0;
    check("b2b_second_rise_seen", second_rise >= 0, 1);
    check("b2b_rise_gap_ge4", (second_rise - first_rise) >= 4, 1);
    drained = 1'b0;
    for (int c = 0; c < 12 && !drained; c++) begin
      @(negedge clk);
      drained = req_ready_o && !rsp_valid_o;
    end
    check("b2b_drained", drained, 1);
    pready_i    = 1'b0;
    rsp_ready_i = 1'b0;
    run_txn(1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'b1100, 2, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
